acc_predecoder_pipe: RTL and testbench
======================================

// Module: acc_predecoder_pipe
// PURPOSE
//  Multi-port, registered accelerator-instruction predecoder. Each of NumPorts
//  offload ports presents an instruction under valid/ready; the block matches it
//  against the OfflInstr table and returns a prd_rsp_t one cycle later.
//  Lowest-index table match wins (priority encode, no OR-merge). Multi-hits are flagged.
//  Sits between the core offload front-end and the accelerator interconnect.
// PARAMETERS
//  NumPorts   2   number of independent request/response ports (>=1)
//  NumInstr   1   number of OfflInstr table entries (>=1)
//  OfflInstr  -   acc_pkg::offl_instr_t [NumInstr]; mask/data/prd_rsp per entry
//  CntWidth   16  width of per-port accept counters (>=1)
// PORTS
//  clk_i            in   1                 clock, rising edge
//  rst_ni           in   1                 asynchronous active-low reset
//  flush_i          in   1                 synchronous flush of all response regs
//  q_valid_i        in   NumPorts          request valid per port
//  q_ready_o        out  NumPorts          request ready per port
//  q_instr_data_i   in   NumPorts x 32     instruction word per port
//  p_valid_o        out  NumPorts          response valid per port
//  p_ready_i        in   NumPorts          response ready per port
//  p_rsp_o          out  NumPorts x prd_rsp_t  {p_accept, p_writeback, p_use_rs}
//  p_multi_hit_o    out  NumPorts          >1 table entry matched this response
//  accept_cnt_o     out  NumPorts x CntWidth  accepted responses per port
// BEHAVIOUR
//  - Reset (rst_ni=0, async): p_valid_o=0, p_rsp_o='0, p_multi_hit_o=0,
//    accept_cnt_o=0. q_ready_o=1 (comb. from empty register).
//  - Match: entry i hits when (OfflInstr[i].instr_mask & instr) == OfflInstr[i].instr_data.
//    Winner: lowest i that hits. rsp = {1, winner.p_writeback, winner.p_use_rs}.
//    No hit: rsp='0 (p_accept=0). This is still a valid response.
//    multi_hit = popcount(hits) > 1.
//  - Per port, one-entry output register. q_ready_o[p] = !p_valid_o[p] | p_ready_i[p].
//  - Request fires on q_valid&q_ready. Register loads at the next edge.
//    p_valid_o rises one cycle after the request fires (latency 1).
//  - Response fires on p_valid&p_ready. With no new request, p_valid clears next edge.
//    A simultaneous request fire and response fire reloads the register.
//    Back-to-back throughput is 1/cycle/port.
//  - While p_valid_o=1 and p_ready_i=0: p_rsp_o and p_multi_hit_o are held stable.
//    q_ready_o=0.
//  - Ports are fully independent: no shared arbitration, no cross-port ordering.
//  - flush_i=1: all p_valid_o clear at the next edge. Requests firing that cycle are dropped.
//    flush beats a simultaneous load. q_ready_o is unaffected by flush_i.
//  - accept_cnt_o[p] increments on each response fire with p_accept=1.
//    It saturates at 2^CntWidth-1 (no wrap). It is cleared only by reset, not by flush.
//  - Mid-operation reset: pending responses are discarded immediately.
//    Counters zero. No response is emitted after release without a new request.
// TESTING
//  1 Single hit: entry0 mask=0x7F data=0x0B, port0 instr=0x0000_100B
//    -> next cycle p_valid=1, p_accept=1, entry0 wb/use_rs, multi_hit=0.
//  2 Priority: entries 0,1 both match 0x0000_002B with different p_use_rs
//    -> rsp carries entry0 fields, multi_hit=1.
//  3 Miss: instr=0x0000_0033 matches nothing -> p_valid=1, p_rsp='0, accept_cnt unchanged.
//  4 Backpressure: p_ready=0 for 3 cycles after a hit -> q_ready=0, rsp stable.
//    p_ready=1 with q_valid=1 -> reload same edge, 1/cycle streaming.
//  5 Flush: flush_i with p_valid=1 and q fire in same cycle
//    -> p_valid=0 next cycle, request dropped, counter unchanged.
//  6 Saturation/reset: CntWidth=2, 5 accepted hits -> cnt=3. rst_ni pulse mid-stall
//    -> p_valid=0, cnt=0 asynchronously.

Source files
------------

// File: rtl/acc_predecoder_pipe_if.sv
// ---------------------------------------------------------------------------
// acc_predecoder_pipe_if
// Offload request/response bundle between the core front-end (master) and the
// accelerator predecoder (slave). All signals are NumPorts wide; bit p belongs
// to port p. Signal suffixes are from the predecoder's point of view.
//   q_valid_i / q_ready_o / q_instr_data_i : request channel
//   p_valid_o / p_ready_i / p_rsp_o        : response channel
//   p_multi_hit_o                          : more than one table entry matched
// ---------------------------------------------------------------------------
interface acc_predecoder_pipe_if #(
    parameter int unsigned NumPorts = 2,
    parameter int unsigned RspW     = 3
);
    logic [NumPorts-1:0]           q_valid_i;
    logic [NumPorts-1:0]           q_ready_o;
    logic [NumPorts-1:0][31:0]     q_instr_data_i;
    logic [NumPorts-1:0]           p_valid_o;
    logic [NumPorts-1:0]           p_ready_i;
    logic [NumPorts-1:0][RspW-1:0] p_rsp_o;
    logic [NumPorts-1:0]           p_multi_hit_o;

    modport master (
        output q_valid_i, q_instr_data_i, p_ready_i,
        input  q_ready_o, p_valid_o, p_rsp_o, p_multi_hit_o
    );

    modport slave (
        input  q_valid_i, q_instr_data_i, p_ready_i,
        output q_ready_o, p_valid_o, p_rsp_o, p_multi_hit_o
    );
endinterface

// File: rtl/acc_predecoder_pipe.sv
// ---------------------------------------------------------------------------
// acc_pkg / acc_predecoder_lane / acc_predecoder_pipe
// Registered multi-port accelerator instruction predecoder. Each port matches
// its instruction against the OfflInstr table (lowest matching entry wins)
// and returns the decoded response one cycle later from a one-entry output
// register. Ports are fully independent.
// Ports (top):
//   clk_i, rst_ni   clock / asynchronous active-low reset
//   flush_i         drop all pending responses and this cycle's requests
//   bus             acc_predecoder_pipe_if.slave request/response bundle
//   accept_cnt_o    per-port saturating count of accepted (p_accept=1) responses
// ---------------------------------------------------------------------------
package acc_pkg;
    typedef struct packed {
        logic p_accept;
        logic p_writeback;
        logic p_use_rs;
    } prd_rsp_t;

    typedef struct packed {
        logic [31:0] instr_data;
        logic [31:0] instr_mask;
        prd_rsp_t    prd_rsp;
    } offl_instr_t;
endpackage

// One port: table match, output register and accept counter.
module acc_predecoder_lane
    import acc_pkg::*;
#(
    parameter int unsigned                NumInstr  = 1,
    parameter int unsigned                CntWidth  = 16,
    parameter offl_instr_t [NumInstr-1:0] OfflInstr = '0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                q_valid_i,
    input  logic [31:0]         q_instr_data_i,
    output logic                q_ready_o,
    output logic                p_valid_o,
    input  logic                p_ready_i,
    output prd_rsp_t            p_rsp_o,
    output logic                p_multi_hit_o,
    output logic [CntWidth-1:0] accept_cnt_o
);
    logic [NumInstr-1:0] hit;
    prd_rsp_t            dec_rsp;
    logic                dec_multi;

    logic                valid_d, valid_q;
    prd_rsp_t            rsp_d, rsp_q;
    logic                multi_d, multi_q;
    logic [CntWidth-1:0] cnt_d, cnt_q;
    logic                q_fire, p_fire;

    for (genvar i = 0; i < NumInstr; i++) begin : g_hit
        assign hit[i] = (OfflInstr[i].instr_mask & q_instr_data_i) == OfflInstr[i].instr_data;
    end

    // Walk from the top entry down so the lowest matching index is written last.
    always_comb begin
        dec_rsp = '0;
        for (int i = int'(NumInstr) - 1; i >= 0; i--) begin
            if (hit[i]) begin
                dec_rsp.p_accept    = 1'b1;
                dec_rsp.p_writeback = OfflInstr[i].prd_rsp.p_writeback;
                dec_rsp.p_use_rs    = OfflInstr[i].prd_rsp.p_use_rs;
            end
        end
        dec_multi = $countones(hit) > 1;
    end

    assign q_ready_o = !valid_q || p_ready_i;
    assign q_fire    = q_valid_i && q_ready_o;
    assign p_fire    = valid_q && p_ready_i;

    always_comb begin
        valid_d = valid_q;
        rsp_d   = rsp_q;
        multi_d = multi_q;
        // Flush wins over a simultaneous load: the request that fired is lost.
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (q_fire) begin
            valid_d = 1'b1;
            rsp_d   = dec_rsp;
            multi_d = dec_multi;
        end else if (p_fire) begin
            valid_d = 1'b0;
        end

        cnt_d = cnt_q;
        if (p_fire && rsp_q.p_accept && (cnt_q != '1)) begin
            cnt_d = cnt_q + CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            rsp_q   <= '0;
            multi_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            rsp_q   <= rsp_d;
            multi_q <= multi_d;
            cnt_q   <= cnt_d;
        end
    end

    assign p_valid_o     = valid_q;
    assign p_rsp_o       = rsp_q;
    assign p_multi_hit_o = multi_q;
    assign accept_cnt_o  = cnt_q;
endmodule

module acc_predecoder_pipe
    import acc_pkg::*;
#(
    parameter int unsigned                NumPorts  = 2,
    parameter int unsigned                NumInstr  = 1,
    parameter offl_instr_t [NumInstr-1:0] OfflInstr = '0,
    parameter int unsigned                CntWidth  = 16
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               flush_i,
    acc_predecoder_pipe_if.slave               bus,
    output logic [NumPorts-1:0][CntWidth-1:0]  accept_cnt_o
);
    prd_rsp_t [NumPorts-1:0] rsp_w;

    for (genvar p = 0; p < NumPorts; p++) begin : g_lane
        acc_predecoder_lane #(
            .NumInstr  (NumInstr),
            .CntWidth  (CntWidth),
            .OfflInstr (OfflInstr)
        ) u_lane (
            .clk_i          (clk_i),
            .rst_ni         (rst_ni),
            .flush_i        (flush_i),
            .q_valid_i      (bus.q_valid_i[p]),
            .q_instr_data_i (bus.q_instr_data_i[p]),
            .q_ready_o      (bus.q_ready_o[p]),
            .p_valid_o      (bus.p_valid_o[p]),
            .p_ready_i      (bus.p_ready_i[p]),
            .p_rsp_o        (rsp_w[p]),
            .p_multi_hit_o  (bus.p_multi_hit_o[p]),
            .accept_cnt_o   (accept_cnt_o[p])
        );
    end

    assign bus.p_rsp_o = rsp_w;
endmodule

// File: tb/tb_acc_predecoder_pipe.sv
module tb_acc_predecoder_pipe;
    import acc_pkg::*;

    localparam int NP = 2;
    localparam int NI = 3;
    localparam int CW = 2;
    localparam int CMAX = (1 << CW) - 1;

    // e0: opcode 0x0B exact; e1 and e2 both match 0x2B (e1 wins), e2 alone matches 0x102B
    localparam offl_instr_t E0 = '{instr_data: 32'h0000_000B, instr_mask: 32'h0000_007F,
                                   prd_rsp: '{p_accept: 1'b0, p_writeback: 1'b1, p_use_rs: 1'b1}};
    localparam offl_instr_t E1 = '{instr_data: 32'h0000_002B, instr_mask: 32'h0000_707F,
                                   prd_rsp: '{p_accept: 1'b0, p_writeback: 1'b1, p_use_rs: 1'b0}};
    localparam offl_instr_t E2 = '{instr_data: 32'h0000_002B, instr_mask: 32'h0000_003F,
                                   prd_rsp: '{p_accept: 1'b0, p_writeback: 1'b0, p_use_rs: 1'b1}};
    localparam offl_instr_t [NI-1:0] TBL = {E2, E1, E0};

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic flush_i = 1'b0;
    logic [NP-1:0][CW-1:0] accept_cnt_o;

    acc_predecoder_pipe_if #(.NumPorts(NP)) bus();

    acc_predecoder_pipe #(
        .NumPorts (NP),
        .NumInstr (NI),
        .OfflInstr(TBL),
        .CntWidth (CW)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .bus          (bus),
        .accept_cnt_o (accept_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Reference decode: collect every matching entry, first one supplies fields.
    // Returns {multi_hit, p_accept, p_writeback, p_use_rs}.
    function automatic logic [3:0] ref_dec(input logic [31:0] instr);
        int hits[$];
        for (int i = 0; i < NI; i++)
            if ((instr & TBL[i].instr_mask) == TBL[i].instr_data) hits.push_back(i);
        if (hits.size() == 0) return 4'b0000;
        return {hits.size() > 1, 1'b1, TBL[hits[0]].prd_rsp.p_writeback, TBL[hits[0]].prd_rsp.p_use_rs};
    endfunction

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  rsp;
        logic        multi;
    } vec_t;

    vec_t vt[6];

    // random-phase model state
    logic       m_valid[NP];
    logic [2:0] m_rsp[NP];
    logic       m_multi[NP];
    int         m_cnt[NP];
    logic [31:0] pool[5];

    initial begin
        int acc_hits;
        int exp_cnt;
        logic [3:0] r;

        vt[0] = '{32'h0000_100B, 3'b111, 1'b0};
        vt[1] = '{32'h0000_002B, 3'b110, 1'b1};
        vt[2] = '{32'h0000_0033, 3'b000, 1'b0};
        vt[3] = '{32'h0000_102B, 3'b101, 1'b0};
        vt[4] = '{32'hFFFF_F00B, 3'b111, 1'b0};
        vt[5] = '{32'h0000_0FAB, 3'b110, 1'b1};

        bus.q_valid_i      = '0;
        bus.q_instr_data_i = '0;
        bus.p_ready_i      = '1;

        // ---------------- reset state
        #3;
        check("rst p_valid", 32'(bus.p_valid_o), 0);
        check("rst q_ready", 32'(bus.q_ready_o), 32'h3);
        check("rst p_rsp", 32'(bus.p_rsp_o), 0);
        check("rst multi", 32'(bus.p_multi_hit_o), 0);
        check("rst cnt", 32'(accept_cnt_o), 0);
        rst_ni = 1'b1;
        step();

        // ---------------- table-driven decode on port 0, counter saturation
        acc_hits = 0;
        for (int i = 0; i < 6; i++) begin
            bus.q_valid_i[0] = 1'b1;
            bus.q_instr_data_i[0] = vt[i].instr;
            bus.p_ready_i[0] = 1'b1;
            #1;
            check($sformatf("vec%0d q_ready", i), 32'(bus.q_ready_o[0]), 1);
            step();
            bus.q_valid_i[0] = 1'b0;
            check($sformatf("vec%0d p_valid", i), 32'(bus.p_valid_o[0]), 1);
            check($sformatf("vec%0d rsp", i), 32'(bus.p_rsp_o[0]), 32'(vt[i].rsp));
            check($sformatf("vec%0d multi", i), 32'(bus.p_multi_hit_o[0]), 32'(vt[i].multi));
            step();
            if (vt[i].rsp[2]) acc_hits++;
            exp_cnt = (acc_hits > CMAX) ? CMAX : acc_hits;
            check($sformatf("vec%0d drain", i), 32'(bus.p_valid_o[0]), 0);
            check($sformatf("vec%0d cnt", i), 32'(accept_cnt_o[0]), 32'(exp_cnt));
        end

        // ---------------- backpressure: stall for 3 cycles, response held
        bus.q_valid_i[0] = 1'b1;
        bus.q_instr_data_i[0] = 32'h0000_100B;
        bus.p_ready_i[0] = 1'b0;
        step();
        bus.q_instr_data_i[0] = 32'h0000_0033;  // must be held off
        for (int k = 0; k < 3; k++) begin
            check($sformatf("stall%0d p_valid", k), 32'(bus.p_valid_o[0]), 1);
            check($sformatf("stall%0d q_ready", k), 32'(bus.q_ready_o[0]), 0);
            check($sformatf("stall%0d rsp", k), 32'(bus.p_rsp_o[0]), 32'h7);
            check($sformatf("stall%0d multi", k), 32'(bus.p_multi_hit_o[0]), 0);
            step();
        end

        // ---------------- asynchronous reset mid-stall
        bus.q_valid_i[0] = 1'b0;
        rst_ni = 1'b0;
        #1;
        check("midrst p_valid", 32'(bus.p_valid_o[0]), 0);
        check("midrst cnt", 32'(accept_cnt_o[0]), 0);
        check("midrst q_ready", 32'(bus.q_ready_o[0]), 1);
        rst_ni = 1'b1;
        step();
        step();
        check("postrst p_valid", 32'(bus.p_valid_o), 0);

        // ---------------- back-to-back streaming
        bus.q_valid_i[0] = 1'b1;
        bus.q_instr_data_i[0] = 32'h0000_002B;
        bus.p_ready_i[0] = 1'b1;
        step();
        bus.q_instr_data_i[0] = 32'h0000_102B;
        check("strm0 p_valid", 32'(bus.p_valid_o[0]), 1);
        check("strm0 rsp", 32'(bus.p_rsp_o[0]), 32'h6);
        check("strm0 multi", 32'(bus.p_multi_hit_o[0]), 1);
        #1;
        check("strm0 q_ready", 32'(bus.q_ready_o[0]), 1);
        step();
        bus.q_valid_i[0] = 1'b0;
        check("strm1 p_valid", 32'(bus.p_valid_o[0]), 1);
        check("strm1 rsp", 32'(bus.p_rsp_o[0]), 32'h5);
        check("strm1 multi", 32'(bus.p_multi_hit_o[0]), 0);
        check("strm1 cnt", 32'(accept_cnt_o[0]), 1);
        step();
        check("strm2 p_valid", 32'(bus.p_valid_o[0]), 0);
        check("strm2 cnt", 32'(accept_cnt_o[0]), 2);

        // ---------------- flush with pending miss and firing request
        bus.q_valid_i[0] = 1'b1;
        bus.q_instr_data_i[0] = 32'h0000_0033;
        bus.p_ready_i[0] = 1'b0;
        step();
        check("fl pre p_valid", 32'(bus.p_valid_o[0]), 1);
        check("fl pre rsp", 32'(bus.p_rsp_o[0]), 0);
        bus.q_instr_data_i[0] = 32'h0000_100B;
        bus.p_ready_i[0] = 1'b1;
        flush_i = 1'b1;
        #1;
        check("fl q_ready", 32'(bus.q_ready_o[0]), 1);
        step();
        flush_i = 1'b0;
        bus.q_valid_i[0] = 1'b0;
        check("fl p_valid", 32'(bus.p_valid_o[0]), 0);
        check("fl cnt", 32'(accept_cnt_o[0]), 2);
        step();
        check("fl dropped", 32'(bus.p_valid_o[0]), 0);

        // ---------------- randomized traffic on both ports vs. reference
        rst_ni = 1'b0;
        #1;
        rst_ni = 1'b1;
        for (int p = 0; p < NP; p++) begin
            m_valid[p] = 1'b0; m_rsp[p] = '0; m_multi[p] = 1'b0; m_cnt[p] = 0;
        end
        pool[0] = 32'h0000_100B; pool[1] = 32'h0000_002B; pool[2] = 32'h0000_0033;
        pool[3] = 32'h0000_102B; pool[4] = 32'h0000_0FAB;
        step();

        for (int c = 0; c < 400; c++) begin
            if (c == 150) begin
                rst_ni = 1'b0;
                #1;
                check("rnd rst p_valid", 32'(bus.p_valid_o), 0);
                check("rnd rst cnt", 32'(accept_cnt_o), 0);
                rst_ni = 1'b1;
                for (int p = 0; p < NP; p++) begin
                    m_valid[p] = 1'b0; m_cnt[p] = 0;
                end
            end
            flush_i = ($urandom_range(0, 15) == 0);
            for (int p = 0; p < NP; p++) begin
                bus.q_valid_i[p] = 1'($urandom_range(0, 1));
                bus.q_instr_data_i[p] = ($urandom_range(0, 5) == 0) ? $urandom : pool[$urandom_range(0, 4)];
                bus.p_ready_i[p] = ($urandom_range(0, 3) != 0);
            end
            #1;
            for (int p = 0; p < NP; p++) begin
                logic qr, qf, pf;
                qr = !m_valid[p] || bus.p_ready_i[p];
                check($sformatf("rnd c%0d p%0d q_ready", c, p), 32'(bus.q_ready_o[p]), 32'(qr));
                check($sformatf("rnd c%0d p%0d p_valid", c, p), 32'(bus.p_valid_o[p]), 32'(m_valid[p]));
                if (m_valid[p]) begin
                    check($sformatf("rnd c%0d p%0d rsp", c, p), 32'(bus.p_rsp_o[p]), 32'(m_rsp[p]));
                    check($sformatf("rnd c%0d p%0d multi", c, p), 32'(bus.p_multi_hit_o[p]), 32'(m_multi[p]));
                end
                check($sformatf("rnd c%0d p%0d cnt", c, p), 32'(accept_cnt_o[p]), 32'(m_cnt[p]));
                qf = bus.q_valid_i[p] && qr;
                pf = m_valid[p] && bus.p_ready_i[p];
                if (pf && m_rsp[p][2] && m_cnt[p] < CMAX) m_cnt[p]++;
                if (flush_i) m_valid[p] = 1'b0;
                else if (qf) begin
                    r = ref_dec(bus.q_instr_data_i[p]);
                    m_valid[p] = 1'b1;
                    m_rsp[p]   = r[2:0];
                    m_multi[p] = r[3];
                end else if (pf) m_valid[p] = 1'b0;
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
